// File: rtl/microwave_control_fsm.sv
// Microwave cooking-sequence controller feeding the countdown timer stage.
// Optional cavity lamp behaviour is enabled by defining DOOR_LIGHT_EN.
//
// Ports:
//   clk          in   system clock, rising edge
//   clr          in   synchronous active-high reset
//   key_valid    in   one-cycle pulse, digit on key_digit
//   key_digit    in   BCD digit (10-15 ignored)
//   start, stop  in   one-cycle debounced pulses
//   door_closed  in   level, 1 = closed
//   timer_zero   in   timer reads 0:00
//   timer_data   out  digit forwarded to the timer
//   timer_load_n out  active-low shift-in strobe
//   timer_clr_n  out  active-low timer clear
//   timer_en_n   out  active-low count enable
//   mag_on       out  magnetron enable
//   beep         out  done beeper
//   light        out  cavity lamp (0 unless DOOR_LIGHT_EN)
//   state_dbg    out  IDLE=0 COOK=1 PAUSE=2 DONE=3
module microwave_control_fsm #(
  parameter int BEEP_CYCLES = 8,
  parameter int STATE_W     = 2
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               key_valid,
  input  logic [3:0]         key_digit,
  input  logic               start,
  input  logic               stop,
  input  logic               door_closed,
  input  logic               timer_zero,
  output logic [3:0]         timer_data,
  output logic               timer_load_n,
  output logic               timer_clr_n,
  output logic               timer_en_n,
  output logic               mag_on,
  output logic               beep,
  output logic               light,
  output logic [STATE_W-1:0] state_dbg
);

  localparam int CNT_W =
    (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = STATE_W'(0),
    COOK  = STATE_W'(1),
    PAUSE = STATE_W'(2),
    DONE  = STATE_W'(3)
  } state_t;

  state_t     state;
  state_t     nxt;
  logic       do_load;
  logic       do_clr;
  logic       start_ok;
  logic       key_ok;
  logic [CNT_W-1:0] cnt;

  assign start_ok = start && door_closed
                    && !timer_zero;
  assign key_ok   = key_valid
                    && (key_digit <= 4'd9);
  assign state_dbg = state;

  // Each branch is a priority chain:
  // door open > stop > timer_zero > start > key.
  always_comb begin
    nxt     = state;
    do_load = 1'b0;
    do_clr  = 1'b0;
    unique case (state)
      IDLE: begin
        if (stop)
          do_clr = 1'b1;
        else if (start_ok)
          nxt = COOK;
        else if (key_ok)
          do_load = 1'b1;
      end
      COOK: begin
        if (!door_closed || stop)
          nxt = PAUSE;
        else if (timer_zero)
          nxt = DONE;
      end
      PAUSE: begin
        if (stop) begin
          nxt    = IDLE;
          do_clr = 1'b1;
        end else if (start_ok) begin
          nxt = COOK;
        end
      end
      DONE: begin
        if (!door_closed || stop || start) begin
          nxt    = IDLE;
          do_clr = 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state        <= IDLE;
      timer_clr_n  <= 1'b0;
      timer_load_n <= 1'b1;
      timer_en_n   <= 1'b1;
      mag_on       <= 1'b0;
      beep         <= 1'b0;
      timer_data   <= 4'd0;
      cnt          <= '0;
    end else begin
      state        <= nxt;
      timer_clr_n  <= !do_clr;
      timer_load_n <= !do_load;
      if (do_load)
        timer_data <= key_digit;
      mag_on       <= (nxt == COOK);
      timer_en_n   <= (nxt != COOK);
      // cnt counts the remaining beep cycles
      // after the entry cycle.
      if (nxt == DONE && state != DONE) begin
        beep <= 1'b1;
        cnt  <= CNT_W'(BEEP_CYCLES - 1);
      end else if (nxt == DONE) begin
        if (cnt != '0)
          cnt <= cnt - 1'b1;
        else
          beep <= 1'b0;
      end else begin
        beep <= 1'b0;
      end
    end
  end

`ifdef DOOR_LIGHT_EN
  always_ff @(posedge clk) begin
    if (clr)
      light <= 1'b0;
    else
      light <= (nxt == COOK) || !door_closed;
  end
`else
  assign light = 1'b0;
`endif

endmodule
